// File: rtl/pulse_handshake_pkg.sv
// rtl/pulse_handshake_pkg.sv - shared types for the pulse handshake launcher
package pulse_handshake_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int MIN_NUM_STAGES = 2;

endpackage

// File: rtl/pulse_tx_ack_sync.sv
// rtl/pulse_tx_ack_sync.sv - acknowledge toggle synchronizer into the source clock
module pulse_tx_ack_sync
  import pulse_handshake_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ack_toggle_i,
  output logic ack_s_o
);

  // Depths below the metastability minimum are silently raised to it.
  localparam int STAGES = (NUM_STAGES < MIN_NUM_STAGES) ? MIN_NUM_STAGES : NUM_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], ack_toggle_i};
    end
  end

  assign ack_s_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// rtl/pulse_handshake_tx.sv - toggle-based pulse CDC launcher with queued requests
// Optional acknowledge timeout enabled by PULSE_HANDSHAKE_TX_TIMEOUT_EN.
module pulse_handshake_tx
  import pulse_handshake_pkg::*;
#(
  parameter int NUM_STAGES     = 2,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 src_clk_i,
  input  logic                 src_reset_i,
  input  logic                 pulse_i,
  input  logic                 ack_toggle_i,
  input  logic                 clr_ovf_i,
  output logic                 req_toggle_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] pending_o,
  output logic                 overflow_o,
  output logic                 timeout_err_o
);

  state_e               state_q, state_d;
  logic                 req_q, req_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 ack_s;
  logic                 launch_queue, launch_direct, count_pulse, drop;

  pulse_tx_ack_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
    .clk_i        (src_clk_i),
    .rst_i        (src_reset_i),
    .ack_toggle_i (ack_toggle_i),
    .ack_s_o      (ack_s)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    pend_d        = pend_q;
    ovf_d         = ovf_q;
    launch_queue  = 1'b0;
    launch_direct = 1'b0;
    count_pulse   = 1'b0;
    drop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q != '0 || pulse_i) begin
          launch_queue  = (pend_q != '0);
          launch_direct = (pend_q == '0);
          req_d         = ~req_q;
          state_d       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A directly launched pulse never enters the queue.
    count_pulse = pulse_i && !launch_direct;
    drop        = count_pulse && !launch_queue && (pend_q == '1);

    if (count_pulse && !launch_queue && !drop) begin
      pend_d = pend_q + CNT_WIDTH'(1);
    end else if (!count_pulse && launch_queue) begin
      pend_d = pend_q - CNT_WIDTH'(1);
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge src_clk_i) begin
    if (src_reset_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              to_q, to_d;

  always_comb begin
    wait_d = wait_q;
    to_d   = to_q;
    if (state_q == IDLE) begin
      if (state_d == WAIT_ACK) wait_d = '0;
    end else begin
      // Counter parks at the limit; the flag fires on the last counted cycle.
      if (wait_q != WAIT_W'(TIMEOUT_CYCLES)) wait_d = wait_q + WAIT_W'(1);
      if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) to_d = 1'b1;
    end
  end

  always_ff @(posedge src_clk_i) begin
    if (src_reset_i) begin
      wait_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end

  assign timeout_err_o = to_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign req_toggle_o = req_q;
  assign busy_o       = (state_q == WAIT_ACK);
  assign pending_o    = pend_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb/tb_pulse_handshake_tx.sv - self-checking bench for pulse_handshake_tx
module tb_pulse_handshake_tx;

  localparam int NS   = 2;
  localparam int CW   = 3;
  localparam int MAXP = (1 << CW) - 1;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0, pulse = 1'b0, ack = 1'b0, clr = 1'b0;
  logic          req_toggle_o, busy_o, overflow_o, timeout_err_o;
  logic [CW-1:0] pending_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy = 0, m_req = 0, m_ovf = 0, m_to = 0;
  int m_pend = 0, m_wait = 0;
  bit m_hist [NS];

  int   toggles = 0;
  int   peak = 0;
  logic last_req = 1'b0;

  always #5 clk = ~clk;

  pulse_handshake_tx #(.NUM_STAGES(NS), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .src_clk_i     (clk),
    .src_reset_i   (rst),
    .pulse_i       (pulse),
    .ack_toggle_i  (ack),
    .clr_ovf_i     (clr),
    .req_toggle_o  (req_toggle_o),
    .busy_o        (busy_o),
    .pending_o     (pending_o),
    .overflow_o    (overflow_o),
    .timeout_err_o (timeout_err_o)
  );

  typedef struct {
    logic p, a, c, r;
    logic e_req, e_busy;
    int   e_pend;
    logic e_ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic model_update(input bit p, input bit a, input bit c, input bit r);
    bit ack_s, launch_q, launch_d, drop;
    int nxt;
    if (r) begin
      m_busy = 0; m_req = 0; m_ovf = 0; m_to = 0; m_pend = 0; m_wait = 0;
      for (int i = 0; i < NS; i++) m_hist[i] = 0;
    end else begin
      ack_s = m_hist[NS-1];
      launch_q = 0; launch_d = 0; drop = 0;
      if (!m_busy) begin
        if (m_pend > 0) launch_q = 1;
        else if (p) launch_d = 1;
        if (launch_q || launch_d) begin
          m_req = ~m_req; m_busy = 1; m_wait = 0;
        end
      end else begin
        m_wait++;
        if (m_wait >= TO) m_to = 1;
        if (ack_s == m_req) m_busy = 0;
      end
      nxt = m_pend + ((p && !launch_d) ? 1 : 0) - (launch_q ? 1 : 0);
      if (nxt > MAXP) begin
        nxt = MAXP; drop = 1;
      end
      m_pend = nxt;
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
      for (int i = NS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = a;
    end
  endtask

  task automatic step(input logic p, input logic a, input logic c, input logic r);
    int exp_to;
    pulse = p; ack = a; clr = c; rst = r;
    @(posedge clk);
    model_update(p, a, c, r);
    #1;
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
    exp_to = int'(m_to);
`else
    exp_to = 0;
`endif
    check("req_toggle", int'(req_toggle_o), int'(m_req));
    check("busy", int'(busy_o), int'(m_busy));
    check("pending", int'(pending_o), m_pend);
    check("overflow", int'(overflow_o), int'(m_ovf));
    check("timeout_err", int'(timeout_err_o), exp_to);
    if (req_toggle_o !== last_req) toggles++;
    last_req = req_toggle_o;
    if (int'(pending_o) > peak) peak = int'(pending_o);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(busy_o == 1'b0 && pending_o == '0) && n < budget) begin
      step(1'b0, req_toggle_o, 1'b0, 1'b0);
      n++;
    end
    check(name, int'(n < budget), 1);
  endtask

  initial begin
    int   t0, n;
    logic a0, ack_r;
    bit   p;

    //            p  a  c  r  req busy pend ovf
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].p, tbl[i].a, tbl[i].c, tbl[i].r);
      check($sformatf("tbl%0d_req", i), int'(req_toggle_o), int'(tbl[i].e_req));
      check($sformatf("tbl%0d_busy", i), int'(busy_o), int'(tbl[i].e_busy));
      check($sformatf("tbl%0d_pend", i), int'(pending_o), tbl[i].e_pend);
      check($sformatf("tbl%0d_ovf", i), int'(overflow_o), int'(tbl[i].e_ovf));
    end

    // Five back-to-back requests
    t0 = toggles; peak = 0;
    a0 = req_toggle_o;
    for (int i = 0; i < 5; i++) step(1'b1, a0, 1'b0, 1'b0);
    drain("b2b_drain", 200);
    check("b2b_toggles", toggles - t0, 5);
    check("b2b_peak", peak, 4);
    check("b2b_ovf", int'(overflow_o), 0);

    // Saturation with acknowledge withheld
    a0 = req_toggle_o;
    for (int i = 0; i < MAXP + 3; i++) step(1'b1, a0, 1'b0, 1'b0);
    check("sat_pend", int'(pending_o), MAXP);
    check("sat_ovf", int'(overflow_o), 1);
    check("sat_busy", int'(busy_o), 1);
    step(1'b0, a0, 1'b1, 1'b0);
    check("clr_ovf", int'(overflow_o), 0);
    drain("sat_drain", 400);

    // Pulse coinciding with a launch from the queue
    a0 = req_toggle_o;
    for (int i = 0; i < 3; i++) step(1'b1, a0, 1'b0, 1'b0);
    check("pre_coinc_pend", int'(pending_o), 2);
    n = 0;
    while (busy_o && n < 50) begin
      step(1'b0, req_toggle_o, 1'b0, 1'b0);
      n++;
    end
    check("coinc_idle_reached", int'(busy_o), 0);
    a0 = req_toggle_o;
    step(1'b1, a0, 1'b0, 1'b0);
    check("coinc_pend", int'(pending_o), 2);
    check("coinc_busy", int'(busy_o), 1);

    // Reset during WAIT_ACK with requests queued
    step(1'b1, a0, 1'b0, 1'b0);
    check("pre_rst_pend", int'(pending_o), 3);
    step(1'b0, a0, 1'b0, 1'b1);
    check("rst_req", int'(req_toggle_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_pend", int'(pending_o), 0);
    check("rst_ovf", int'(overflow_o), 0);
    check("rst_to", int'(timeout_err_o), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_idle", int'(busy_o), 0);

    // Randomized traffic with an echoing destination
    ack_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p = (i < 1500) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) ack_r = m_req;
      if ($urandom_range(0, 199) == 0) ack_r = ~ack_r;
      step(p, ack_r, ($urandom_range(0, 39) == 0), ($urandom_range(0, 499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
